if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the pipelined RV32 core. Holds the fetch PC and issues addresses to a synchronous-read instruction memory with one-cycle read latency. Captures returned words into the IF/ID pipeline register, using a one-entry skid buffer to absorb decode stalls. Consumes the branch unit's `PcSel`/`BrPC` redirect and discards every wrong-path fetch.

## Interface
Parameters:
- `PC_W`, 9: width of the fetch PC and instruction memory byte address.
- `RESET_PC`, 0: fetch address after reset, `PC_W` bits, word aligned.

Ports:
- `clk`  input  1  core clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `Stall`  input  1  hazard unit holds IF/ID; ID accepts when `Stall`=0.
- `PcSel`  input  1  redirect request from the branch unit (taken branch or jump).
- `BrPC`  input  32  redirect target; only bits `[PC_W-1:2]` are used.
- `imem_req`  output  1  read issued this cycle.
- `imem_addr`  output  PC_W  read address; equals the fetch PC.
- `imem_rdata`  input  32  read data; valid in the cycle after a read is issued.
- `Cur_PC_D`  output  PC_W  PC of the instruction held in IF/ID.
- `Inst_D`  output  32  instruction held in IF/ID.
- `Valid_D`  output  1  IF/ID holds a live instruction.

## Operation
- State:
  - fetch PC `pc_q`.
  - in-flight flag `req_vld_q` with its address `req_pc_q`.
  - skid entry `skid_vld`/`skid_pc`/`skid_inst`.
  - IF/ID register `Valid_D`/`Cur_PC_D`/`Inst_D`.
- Issue rule: `imem_req = !reset && !PcSel && !skid_vld && !(req_vld_q && Valid_D && Stall)`.
  - On issue: `req_pc_q` ← `pc_q`, `req_vld_q` ← 1, `pc_q` ← `pc_q + 4` (mod 2^PC_W, wraps to 0).
  - With no issue: `req_vld_q` ← 0 and `pc_q` holds.
- IF/ID load, when `!Valid_D || !Stall`:
  - source priority is skid entry, then in-flight response.
  - with neither present, `Valid_D` ← 0.
  - a skid entry consumed this way clears `skid_vld`.
- Skid fill: in-flight response arrives while `Valid_D && Stall` → it is written to the skid entry. The issue rule guarantees the skid is empty when this happens.
- Simultaneous skid drain and response arrival:
  - the skid entry moves to IF/ID.
  - the response is written into the skid.
- Redirect (`PcSel`=1) overrides `Stall`:
  - `pc_q` ← {`BrPC[PC_W-1:2]`, 2'b00}.
  - `Valid_D`, `skid_vld` and `req_vld_q` are cleared; `imem_rdata` is dropped.
  - no issue occurs in that cycle.
- Ordering: instructions reach IF/ID in program order, with none lost or duplicated outside redirects.
- Reset wins over everything:
  - `pc_q` = `RESET_PC`.
  - `Valid_D`, `skid_vld`, `req_vld_q`, `imem_req` = 0.
  - `Cur_PC_D` = 0, `Inst_D` = 32'h0000_0013 (NOP).
  - Reset mid-stall or mid-redirect discards all held state.

## Timing
- Cycle 0 is the first cycle with `reset`=0:
  - issue at `RESET_PC` in cycle 0.
  - data arrives in cycle 1.
  - `Valid_D`=1 with `Cur_PC_D`=`RESET_PC` from cycle 2.
- Steady state with no stalls: one instruction per cycle, consecutive PCs +4.
- Redirect asserted in cycle t:
  - t+1: issue at the target.
  - t+3: first target instruction valid in IF/ID.
  - `Valid_D`=0 in t+1 and t+2 (two-bubble penalty).
- Stall release:
  - the held instruction advances in the same cycle `Stall` falls.
  - the skid entry follows in the next cycle, with no bubble.
- Under sustained `Stall`, at most 2 instructions are held (IF/ID plus skid) and `imem_req` stays low.

## Structure
- Shared core package `core_pkg`:
  - `if_id_t` struct {pc, inst, valid}.
  - `NOP_INST` = 32'h0000_0013.
  - `PC_INC` = 4.
- One sub-module `fetch_skid_buf`: a one-entry buffer with valid/ready in and out, holding `if_id_t`. The top level holds the PC register, issue logic and redirect/flush.

## Test plan
- Reset release with `RESET_PC`=0 and no stalls → `Valid_D` from cycle 2, PCs 0, 4, 8, 12 on consecutive cycles, `Inst_D` matching memory.
- `Stall` high for 5 cycles while streaming → `imem_req` low after the skid fills, `Cur_PC_D` held. After release, next two PCs arrive on consecutive cycles with no gap or duplicate.
- `PcSel`=1, `BrPC`=0x40 in cycle t with skid full and `Stall`=1 → `Valid_D`=0 at t+1 and t+2; at t+3 `Cur_PC_D`=0x40, and no stale PC ever appears.
- `BrPC`=0x1FE with `PC_W`=9 → fetch at 0x1FC, then 0x000 (wrap).
- `PcSel` and `Stall` both high on the same cycle → redirect wins; IF/ID is flushed despite the stall.
- `reset` asserted for 1 cycle mid-stream with skid full → next cycle all valids are 0, `Inst_D`=NOP, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the pipelined RV32 core front end.
//   NOP_INST : canonical RV32 NOP (addi x0, x0, 0), loaded into IF/ID on reset
//   PC_INC   : byte distance between consecutive sequential fetches
//   if_id_t  : one IF/ID pipeline entry (fetch PC, instruction word, live flag)
// ---------------------------------------------------------------------------
package core_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int          PC_INC   = 4;

  // The pc field is full width so the struct can be shared by blocks with
  // different PC widths; narrower users take the low bits.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  // Empty IF/ID entry: PC 0, NOP, not live.
  function automatic if_id_t if_id_empty();
    if_id_t e;
    e.pc    = 32'h0;
    e.inst  = NOP_INST;
    e.valid = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory read port used by the fetch stage.
//   imem_req   : a read is issued this cycle at imem_addr
//   imem_addr  : byte address of the read (PC_W bits, word aligned)
//   imem_rdata : read data, valid in the cycle after imem_req was high
// Handshake: there is no ready/backpressure on this port. The memory accepts
// every request and returns data exactly one cycle later; the fetch stage is
// responsible for only issuing a request when it has room for the response.
// Modports: master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface if_fetch_unit_if #(
  parameter int PC_W = 9
) ();

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
// One-entry buffer holding an if_id_t, used to park a memory response that
// arrives while decode is stalled.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_flush      : drop the held entry (redirect)
//   i_in_valid   : offer i_in_data for storage
//   o_in_ready   : entry can be written this cycle (empty, or draining now)
//   i_in_data    : entry to store
//   o_out_valid  : an entry is held
//   o_out_data   : the held entry
//   i_out_ready  : consumer takes the held entry this cycle
// Handshake: a transfer happens on a side when its valid and ready are both
// high in the same cycle; a simultaneous drain and fill replaces the entry.
// ---------------------------------------------------------------------------
module fetch_skid_buf
  import core_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_flush,
  input  logic   i_in_valid,
  output logic   o_in_ready,
  input  if_id_t i_in_data,
  output logic   o_out_valid,
  output if_id_t o_out_data,
  input  logic   i_out_ready
);

  logic   r_vld;
  if_id_t r_data;

  assign o_in_ready  = !r_vld || i_out_ready;
  assign o_out_valid = r_vld;
  assign o_out_data  = r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld  <= 1'b0;
      r_data <= if_id_empty();
    end else if (i_flush) begin
      r_vld  <= 1'b0;
    end else if (i_in_valid && o_in_ready) begin
      r_vld  <= 1'b1;
      r_data <= i_in_data;
    end else if (i_out_ready) begin
      r_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: holds the fetch PC, issues reads to a one-cycle
// latency instruction memory, and loads returned words into the IF/ID
// register. A one-entry skid buffer absorbs the response that is already in
// flight when decode stalls. A redirect (PcSel) flushes everything in flight.
// Parameters:
//   PC_W     : fetch PC / instruction memory byte address width (< 32)
//   RESET_PC : first fetch address after reset (word aligned)
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   Stall      : hold IF/ID; decode accepts when Stall = 0
//   PcSel      : redirect request from the branch unit
//   BrPC       : redirect target, bits [PC_W-1:2] used
//   imem       : instruction memory read port (master side)
//   Cur_PC_D   : PC of the instruction in IF/ID
//   Inst_D     : instruction in IF/ID
//   Valid_D    : IF/ID holds a live instruction
// ---------------------------------------------------------------------------
module if_fetch_unit
  import core_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic                  PcSel,
  input  logic [31:0]           BrPC,
  if_fetch_unit_if.master       imem,
  output logic [PC_W-1:0]       Cur_PC_D,
  output logic [31:0]           Inst_D,
  output logic                  Valid_D
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

  // Fetch PC and the single outstanding request.
  logic [PC_W-1:0] r_pc;
  logic            r_req_vld;
  logic [PC_W-1:0] r_req_pc;

  // IF/ID pipeline register.
  logic            r_valid_d;
  logic [PC_W-1:0] r_cur_pc_d;
  logic [31:0]     r_inst_d;

  logic            w_issue;
  logic            w_ifid_load;
  logic            w_rsp_vld;
  logic            w_skid_push;
  logic            w_skid_in_ready;
  logic            w_skid_vld;
  if_id_t          w_skid_in;
  if_id_t          w_skid_out;
  logic [PC_W-1:0] w_redirect_pc;
  logic            w_unused;

  // A response is present in the cycle after an issue.
  assign w_rsp_vld   = r_req_vld;

  // IF/ID takes a new entry whenever it is empty or decode is advancing.
  assign w_ifid_load = !r_valid_d || !Stall;

  // Only issue when the response is guaranteed a home next cycle: the skid
  // must be empty, and it must not be about to fill with the response that is
  // arriving right now (that is exactly the req_vld && Valid_D && Stall case).
  assign w_issue = !reset && !PcSel && !w_skid_vld &&
                   !(r_req_vld && r_valid_d && Stall);

  assign imem.imem_req  = w_issue;
  assign imem.imem_addr = r_pc;

  assign w_redirect_pc = {BrPC[PC_W-1:2], 2'b00};

  // The response goes to the skid when IF/ID cannot take it directly: either
  // IF/ID is stalled, or the skid is draining into IF/ID this same cycle
  // (older entry first keeps program order).
  assign w_skid_push = w_rsp_vld && !PcSel && (w_skid_vld || !w_ifid_load);

  always_comb begin
    w_skid_in       = if_id_empty();
    w_skid_in.pc    = 32'(r_req_pc);
    w_skid_in.inst  = imem.imem_rdata;
    w_skid_in.valid = 1'b1;
  end

  fetch_skid_buf u_skid (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (PcSel),
    .i_in_valid  (w_skid_push),
    .o_in_ready  (w_skid_in_ready),
    .i_in_data   (w_skid_in),
    .o_out_valid (w_skid_vld),
    .o_out_data  (w_skid_out),
    .i_out_ready (w_ifid_load)
  );

  // Fetch PC and outstanding-request tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_req_vld <= 1'b0;
      r_req_pc  <= '0;
    end else if (PcSel) begin
      r_pc      <= w_redirect_pc;
      r_req_vld <= 1'b0;
    end else begin
      r_req_vld <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + PC_STEP;
      end
    end
  end

  // IF/ID register: skid entry first, then the arriving response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_d  <= 1'b0;
      r_cur_pc_d <= '0;
      r_inst_d   <= NOP_INST;
    end else if (PcSel) begin
      r_valid_d  <= 1'b0;
    end else if (w_ifid_load) begin
      if (w_skid_vld) begin
        r_valid_d  <= 1'b1;
        r_cur_pc_d <= w_skid_out.pc[PC_W-1:0];
        r_inst_d   <= w_skid_out.inst;
      end else if (w_rsp_vld) begin
        r_valid_d  <= 1'b1;
        r_cur_pc_d <= r_req_pc;
        r_inst_d   <= imem.imem_rdata;
      end else begin
        r_valid_d  <= 1'b0;
      end
    end
  end

  assign Valid_D  = r_valid_d;
  assign Cur_PC_D = r_cur_pc_d;
  assign Inst_D   = r_inst_d;

  // Bits that carry no information here: upper PC bits of the shared struct,
  // its valid flag (tracked by o_out_valid), the skid ready (the issue rule
  // guarantees room) and the BrPC bits outside the word address.
  assign w_unused = ^{w_skid_out.pc[31:PC_W], w_skid_out.valid, w_skid_in_ready,
                      BrPC[31:PC_W], BrPC[1:0]};

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  import core_pkg::*;

  localparam int PC_W = 9;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic Stall;
  logic PcSel;
  logic [31:0] BrPC;
  logic [PC_W-1:0] Cur_PC_D;
  logic [31:0] Inst_D;
  logic Valid_D;

  int n_total;
  int n_bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  if_fetch_unit_if #(.PC_W(PC_W)) bus ();

  if_fetch_unit #(.PC_W(PC_W), .RESET_PC(9'h000)) dut (
    .clk      (clk),
    .reset    (reset),
    .Stall    (Stall),
    .PcSel    (PcSel),
    .BrPC     (BrPC),
    .imem     (bus.master),
    .Cur_PC_D (Cur_PC_D),
    .Inst_D   (Inst_D),
    .Valid_D  (Valid_D)
  );

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
    return 32'h1000_0000 | {23'h0, a};
  endfunction

  // Synchronous-read memory, one-cycle latency; junk when not read.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= mem_word(bus.imem_addr);
    else              bus.imem_rdata <= 32'hDEAD_BEEF;
  end

  // ---------------- driver / checkers ----------------
  // Apply inputs for the next rising edge, then settle before checking.
  task automatic step(input logic rst, input logic stl, input logic sel,
                      input logic [31:0] br);
    @(negedge clk);
    reset = rst;
    Stall = stl;
    PcSel = sel;
    BrPC  = br;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // IF/ID contents: valid flag, and PC/instruction when valid.
  task automatic chk_d(input string tag, input logic v,
                       input logic [PC_W-1:0] pc);
    chk({tag, ".valid"}, 32'(Valid_D), 32'(v));
    if (v) begin
      chk({tag, ".pc"},   32'(Cur_PC_D), 32'(pc));
      chk({tag, ".inst"}, Inst_D, mem_word(pc));
    end
  endtask

  // Memory request: req flag, and address when requesting.
  task automatic chk_req(input string tag, input logic r,
                         input logic [PC_W-1:0] addr);
    chk({tag, ".req"}, 32'(bus.imem_req), 32'(r));
    if (r) chk({tag, ".addr"}, 32'(bus.imem_addr), 32'(addr));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_total = 0;
    n_bad   = 0;
    reset = 1'b1;
    Stall = 1'b0;
    PcSel = 1'b0;
    BrPC  = 32'h0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst.valid", 32'(Valid_D), 32'h0);
    chk("rst.pc",    32'(Cur_PC_D), 32'h0);
    chk("rst.inst",  Inst_D, NOP_INST);
    chk("rst.req",   32'(bus.imem_req), 32'h0);

    // Reset release: issue at 0 in cycle 0, IF/ID live from cycle 2.
    step(0, 0, 0, 0); chk_d("c0", 0, 0);      chk_req("c0", 1, 9'h000);
    step(0, 0, 0, 0); chk_d("c1", 0, 0);      chk_req("c1", 1, 9'h004);
    step(0, 0, 0, 0); chk_d("c2", 1, 9'h000); chk_req("c2", 1, 9'h008);
    step(0, 0, 0, 0); chk_d("c3", 1, 9'h004);
    step(0, 0, 0, 0); chk_d("c4", 1, 9'h008);

    // Stall for 5 cycles: response 16 parks in the skid, PC 12 held.
    step(0, 1, 0, 0); chk_d("s5", 1, 9'h00C); chk_req("s5", 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0); chk_d("s_hold", 1, 9'h00C); chk_req("s_hold", 0, 0);
    end
    // Release: 12 leaves now, 16 follows straight from the skid.
    step(0, 0, 0, 0); chk_d("c10", 1, 9'h00C); chk_req("c10", 0, 0);
    step(0, 0, 0, 0); chk_d("c11", 1, 9'h010); chk_req("c11", 1, 9'h014);
    step(0, 0, 0, 0); chk_d("c12", 0, 0);      chk_req("c12", 1, 9'h018);
    step(0, 0, 0, 0); chk_d("c13", 1, 9'h014);

    // Fill the skid, then redirect to 0x40 while stalled.
    step(0, 1, 0, 0);        chk_d("c14", 1, 9'h018); chk_req("c14", 0, 0);
    step(0, 1, 1, 32'h40);   chk_d("c15", 1, 9'h018); chk_req("c15", 0, 0);
    step(0, 0, 0, 0);        chk_d("r1", 0, 0);       chk_req("r1", 1, 9'h040);
    step(0, 0, 0, 0);        chk_d("r2", 0, 0);       chk_req("r2", 1, 9'h044);
    step(0, 0, 0, 0);        chk_d("r3", 1, 9'h040);
    // Redirect and Stall together, to an unaligned target near the top.
    step(0, 1, 1, 32'h1FE);  chk_d("c19", 1, 9'h044); chk_req("c19", 0, 0);
    step(0, 0, 0, 0);        chk_d("w1", 0, 0);       chk_req("w1", 1, 9'h1FC);
    step(0, 0, 0, 0);        chk_d("w2", 0, 0);       chk_req("w2", 1, 9'h000);
    step(0, 0, 0, 0);        chk_d("w3", 1, 9'h1FC);  chk_req("w3", 1, 9'h004);

    // Reset for one cycle with the skid full.
    step(0, 1, 0, 0);        chk_d("c23", 1, 9'h000); chk_req("c23", 0, 0);
    step(1, 1, 0, 0);        chk_req("c24", 0, 0);
    step(0, 0, 0, 0);
    chk("x0.valid", 32'(Valid_D), 32'h0);
    chk("x0.pc",    32'(Cur_PC_D), 32'h0);
    chk("x0.inst",  Inst_D, NOP_INST);
    chk_req("x0", 1, 9'h000);
    step(0, 0, 0, 0);        chk_d("x1", 0, 0);       chk_req("x1", 1, 9'h004);
    step(0, 0, 0, 0);        chk_d("x2", 1, 9'h000);
    step(0, 0, 0, 0);        chk_d("x3", 1, 9'h004);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
